// File: rtl/scroll_sequencer.sv
// scroll_sequencer
//   Turns the vsync level into a one-cycle frame_tick and uses it to run a
//   scroll-offset sequencer: IDLE -> START (START_FRAMES ticks) -> RUN <-> PAUSED.
//   In RUN, every frame tick advances x_offset by the latched step, modulo WRAP,
//   forward or in reverse.
//
// Ports
//   clk          pixel clock (single domain)
//   reset        synchronous, active-high
//   vsync        vertical sync level, sampled on clk
//   speed_in     requested step in pixels per frame (0 behaves as 1)
//   dir_in       0 = offset increases, 1 = offset decreases
//   pause_in     level request to freeze scrolling
//   x_offset     scroll offset, always 0..WRAP-1
//   frame_tick   one-cycle pulse at the start of each frame
//   running      high while the sequencer is in RUN
//   frame_count  free-running frame counter, wraps 255 -> 0
//   state_dbg    current sequencer state (0 IDLE, 1 START, 2 RUN, 3 PAUSED)
//
// Handshake: none. vsync is a free-running level, and every other input is
// only acted on in the cycle where frame_tick is high.
module scroll_sequencer #(
   parameter int WRAP         = 400,
   parameter int RESET_SPEED  = 4,
   parameter int START_FRAMES = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       vsync,
   input  logic [3:0] speed_in,
   input  logic       dir_in,
   input  logic       pause_in,
   output logic [9:0] x_offset,
   output logic       frame_tick,
   output logic       running,
   output logic [7:0] frame_count,
   output logic [1:0] state_dbg
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_START  = 2'd1;
   localparam logic [1:0] ST_RUN    = 2'd2;
   localparam logic [1:0] ST_PAUSED = 2'd3;

   localparam logic [10:0] WRAP_W    = 11'(WRAP);
   localparam logic [3:0]  RESET_SPD = 4'(RESET_SPEED);
   localparam logic [7:0]  START_CNT = 8'(START_FRAMES);

   logic [1:0]  state_q, state_d;
   logic        vsync_q, vsync_d;
   logic        frame_tick_q, frame_tick_d;
   logic [9:0]  x_offset_q, x_offset_d;
   logic        running_q, running_d;
   logic [7:0]  frame_count_q, frame_count_d;
   logic [3:0]  spd_q, spd_d;
   logic        dir_q, dir_d;
   logic [7:0]  dly_q, dly_d;

   logic [10:0] step;
   logic [10:0] off_ext;
   logic [10:0] fwd_sum;
   logic [10:0] fwd_val;
   logic [10:0] rev_val;
   logic [10:0] adv_val;

   always_comb begin
      state_d       = state_q;
      x_offset_d    = x_offset_q;
      frame_count_d = frame_count_q;
      dly_d         = dly_q;

      // Edge detect: a tick needs a high sample preceded by a low one, so a
      // vsync held high produces exactly one tick.
      vsync_d      = vsync;
      frame_tick_d = vsync & ~vsync_q;

      // speed/dir are captured on the tick and the same tick uses the
      // captured value; between ticks the held copy is what is presented.
      spd_d = frame_tick_q ? speed_in : spd_q;
      dir_d = frame_tick_q ? dir_in   : dir_q;

      step    = (spd_d == 4'd0) ? 11'd1 : {7'd0, spd_d};
      off_ext = {1'b0, x_offset_q};

      // Modular add/subtract by a single conditional correction, valid
      // because step < WRAP and the offset is always < WRAP.
      fwd_sum = off_ext + step;
      fwd_val = (fwd_sum >= WRAP_W) ? (fwd_sum - WRAP_W) : fwd_sum;
      rev_val = (off_ext < step) ? (off_ext + WRAP_W - step) : (off_ext - step);
      adv_val = dir_d ? rev_val : fwd_val;

      if (frame_tick_q) begin
         frame_count_d = frame_count_q + 8'd1;
         case (state_q)
            ST_IDLE: begin
               state_d = ST_START;
               dly_d   = 8'd0;
            end
            ST_START: begin
               dly_d = dly_q + 8'd1;
               if (dly_q + 8'd1 == START_CNT) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (pause_in) begin
                  state_d = ST_PAUSED;
               end else begin
                  x_offset_d = adv_val[9:0];
               end
            end
            default: begin
               // PAUSED: leaving on this tick still leaves the offset alone.
               if (!pause_in) begin
                  state_d = ST_RUN;
               end
            end
         endcase
      end

      running_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         vsync_q       <= 1'b1;
         frame_tick_q  <= 1'b0;
         x_offset_q    <= 10'd0;
         running_q     <= 1'b0;
         frame_count_q <= 8'd0;
         spd_q         <= RESET_SPD;
         dir_q         <= 1'b0;
         dly_q         <= 8'd0;
      end else begin
         state_q       <= state_d;
         vsync_q       <= vsync_d;
         frame_tick_q  <= frame_tick_d;
         x_offset_q    <= x_offset_d;
         running_q     <= running_d;
         frame_count_q <= frame_count_d;
         spd_q         <= spd_d;
         dir_q         <= dir_d;
         dly_q         <= dly_d;
      end
   end

   assign x_offset    = x_offset_q;
   assign frame_tick  = frame_tick_q;
   assign running     = running_q;
   assign frame_count = frame_count_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_scroll_sequencer.sv
// Self-checking bench for scroll_sequencer: directed start-up, wrap, pause,
// reset and long-vsync cases, then randomized frames, with a behavioural
// model compared against the DUT outputs on every cycle.
module tb_scroll_sequencer;

  localparam int TB_WRAP   = 400;
  localparam int TB_RSPEED = 4;
  localparam int TB_SFR    = 1;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       vsync;
  logic [3:0] speed_in;
  logic       dir_in;
  logic       pause_in;
  logic [9:0] x_offset;
  logic       frame_tick;
  logic       running;
  logic [7:0] frame_count;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  scroll_sequencer #(
    .WRAP(TB_WRAP),
    .RESET_SPEED(TB_RSPEED),
    .START_FRAMES(TB_SFR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .vsync(vsync),
    .speed_in(speed_in),
    .dir_in(dir_in),
    .pause_in(pause_in),
    .x_offset(x_offset),
    .frame_tick(frame_tick),
    .running(running),
    .frame_count(frame_count),
    .state_dbg(state_dbg)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // ---------------- behavioural model ----------------
  // Modes: 0 idle, 1 start, 2 run, 3 paused.
  int m_mode, m_left, m_off, m_fc, m_step;
  bit m_tick, m_prev_vs;

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_left = 0; m_off = 0; m_fc = 0;
      m_tick = 1'b0; m_prev_vs = 1'b1;
    end else begin
      if (m_tick) begin
        m_fc = (m_fc + 1) % 256;
        case (m_mode)
          0: begin m_mode = 1; m_left = TB_SFR; end
          1: begin m_left = m_left - 1; if (m_left == 0) m_mode = 2; end
          2: begin
            if (pause_in) m_mode = 3;
            else begin
              m_step = (speed_in == 0) ? 1 : int'(speed_in);
              if (dir_in) m_off = (m_off - m_step + TB_WRAP) % TB_WRAP;
              else        m_off = (m_off + m_step) % TB_WRAP;
            end
          end
          default: if (!pause_in) m_mode = 2;
        endcase
      end
      m_tick = vsync && !m_prev_vs;
      m_prev_vs = vsync;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      n_cmp++;
      if (int'(x_offset) !== m_off || frame_tick !== m_tick ||
          running !== (m_mode == 2) || int'(frame_count) !== m_fc ||
          int'(state_dbg) !== m_mode) begin
        n_bad++;
        $display("FAIL cycle_cmp t=%0t: got off=%0d tick=%b run=%b fc=%0d st=%0d expected off=%0d tick=%b run=%b fc=%0d st=%0d",
                 $time, x_offset, frame_tick, running, frame_count, state_dbg,
                 m_off, m_tick, (m_mode == 2), m_fc, m_mode);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    vsync = 1'b1;
    repeat (hi) @(negedge clk);
    vsync = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic frame(input int spd, input bit dir);
    speed_in = 4'(spd);
    dir_in   = dir;
    pulse(2, 3);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  int tc;

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; vsync = 1'b0; speed_in = 4'd4; dir_in = 1'b0; pause_in = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("reset_offset", x_offset, 0);
    check("reset_fc", frame_count, 0);
    check("reset_running", running, 0);
    reset = 1'b0;
    @(negedge clk);

    // start-up
    frame(4, 0);
    check("tick1_state_start", state_dbg, 1);
    frame(4, 0);
    check("tick2_running", running, 1);
    check("tick2_no_update", x_offset, 0);
    frame(4, 0);
    check("tick3_offset", x_offset, 4);
    check("tick3_fc", frame_count, 3);

    // reverse to 396, then forward wrap
    frame(4, 1);
    frame(4, 1);
    check("rev_to_396", x_offset, 396);
    frame(15, 0);
    check("fwd_wrap_11", x_offset, 11);
    frame(15, 0);
    check("fwd_26", x_offset, 26);

    // down to 3, then reverse wrap and speed 0
    frame(15, 1);
    frame(8, 1);
    check("rev_to_3", x_offset, 3);
    frame(5, 1);
    check("rev_wrap_398", x_offset, 398);
    frame(0, 1);
    check("speed0_397", x_offset, 397);

    // walk to 100
    frame(3, 0);
    check("fwd_wrap_0", x_offset, 0);
    for (int i = 0; i < 6; i++) frame(15, 0);
    frame(10, 0);
    check("offset_100", x_offset, 100);

    // pause
    pause_in = 1'b1;
    frame(10, 0);
    check("pause_running_low", running, 0);
    check("pause_hold1", x_offset, 100);
    frame(10, 0);
    frame(10, 0);
    pause_in = 1'b0;
    frame(10, 0);
    check("release_hold", x_offset, 100);
    check("release_running", running, 1);
    frame(10, 0);
    check("after_release_110", x_offset, 110);

    // mid-operation reset
    do_reset();
    check("midreset_offset", x_offset, 0);
    check("midreset_fc", frame_count, 0);
    check("midreset_running", running, 0);
    check("midreset_state", state_dbg, 0);
    check("midreset_tick", frame_tick, 0);
    @(negedge clk);

    // long vsync: exactly one tick
    tc = 0;
    vsync = 1'b1;
    for (int i = 0; i < 1600; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) tc++;
    end
    check("long_vsync_ticks", tc, 1);

    // reset released with vsync high: no tick until a fresh rise
    do_reset();
    tc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) tc++;
    end
    check("vsync_high_at_reset_ticks", tc, 0);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
    vsync = 1'b1;
    tc = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) tc++;
    end
    check("rerise_ticks", tc, 1);
    vsync = 1'b0;
    repeat (2) @(negedge clk);

    // randomized frames, including mid-frame input changes
    do_reset();
    for (int i = 0; i < 400; i++) begin
      speed_in = 4'($urandom_range(0, 15));
      dir_in   = 1'($urandom_range(0, 1));
      pause_in = ($urandom_range(0, 4) == 0);
      vsync = 1'b1;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) speed_in = 4'($urandom_range(0, 15));
      vsync = 1'b0;
      repeat ($urandom_range(1, 6)) @(negedge clk);
      if (i == 200) do_reset();
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scroll_sequencer.md
SCROLL_SEQUENCER -- requirements
Module: scroll_sequencer

Interface
REQ-001 Parameter WRAP, default 400: modulus of the scroll offset; legal range 16..1023.
REQ-002 Parameter RESET_SPEED, default 4: step size used in the first running frame after reset.
REQ-003 Parameter START_FRAMES, default 1: number of frame ticks spent in START before scrolling begins; legal range 1..255.
REQ-004 Port clk, input, 1 bit: pixel clock; the block has this single clock domain.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port vsync, input, 1 bit: active-high vertical sync level from hvsync_generator, sampled on clk.
REQ-007 Port speed_in, input, 4 bits: requested step size in pixels per frame.
REQ-008 Port dir_in, input, 1 bit: scroll direction; 0 = forward (offset increases), 1 = reverse.
REQ-009 Port pause_in, input, 1 bit: level request to freeze scrolling.
REQ-010 Port x_offset, output, 10 bits: scroll offset driven to the scene and player logic; always in 0..WRAP-1.
REQ-011 Port frame_tick, output, 1 bit: single-cycle pulse marking the start of a frame.
REQ-012 Port running, output, 1 bit: high while the block is in state RUN.
REQ-013 Port frame_count, output, 8 bits: free-running frame counter.

Function
REQ-014 Edge detect:
- vsync is registered into vsync_q.
- frame_tick is registered high for exactly one cycle on the edge after vsync=1 is sampled while vsync_q=0.
REQ-015 States:
- IDLE: entered on reset.
- START: waits out START_FRAMES ticks.
- RUN: offset advances.
- PAUSED: offset frozen.
REQ-016 Transitions: all transitions occur only on cycles where frame_tick=1.
- IDLE -> START on the first tick.
- START -> RUN when the frame-delay counter reaches START_FRAMES.
- RUN -> PAUSED if pause_in=1.
- PAUSED -> RUN if pause_in=0.
REQ-017 Input latching: speed_in and dir_in are latched only on frame_tick cycles; mid-frame changes have no effect until the next tick.
REQ-018 Step size:
- step = latched speed, or 1 if the latched speed is 0.
- The first RUN update uses RESET_SPEED if no latch has occurred since reset.
REQ-019 Offset update: on a frame_tick cycle in RUN with pause_in=0, x_offset updates with one-cycle latency (the new value is visible the cycle after frame_tick).
- Forward: x_offset + step, minus WRAP if the sum is >= WRAP.
- Reverse: x_offset - step, plus WRAP if x_offset < step.
- Arithmetic is at least 11 bits wide; no modulo/divide operator is used.
REQ-020 No offset change occurs on the tick that enters PAUSED, on the tick that leaves PAUSED, or in IDLE/START.
REQ-021 frame_count increments by 1 on every frame_tick in every state except during reset; it wraps 255 -> 0.
REQ-022 running is registered and equals (state == RUN).
REQ-023 When vsync stays high for many cycles, only one frame_tick is produced; a glitch-free re-rise after a low sample produces a new tick.

Reset
REQ-024 On any clk edge with reset=1, the block loads:
- state = IDLE
- x_offset = 0
- frame_tick = 0
- running = 0
- frame_count = 0
- vsync_q = 1
- latched speed = RESET_SPEED
- latched dir = 0
- frame-delay counter = 0
REQ-025 Because vsync_q resets to 1, a vsync that is already high when reset releases produces no tick.
REQ-026 Reset asserted mid-frame or while PAUSED overrides all other activity on the same edge.

Verification
REQ-027 Scenario (start-up): reset, then 3 vsync pulses with speed_in=4, dir_in=0, START_FRAMES=1.
- Tick 1: enter START.
- Tick 2: enter RUN, no offset update.
- Tick 3: x_offset = 4.
- frame_count = 3.
REQ-028 Scenario (forward wrap): x_offset=396, speed_in=15, dir_in=0, tick -> x_offset = 11; next tick -> 26.
REQ-029 Scenario (reverse wrap): x_offset=3, speed_in=5, dir_in=1, tick -> x_offset = 398. With speed_in=0 on the following tick -> x_offset = 397.
REQ-030 Scenario (pause): in RUN at x_offset=100, hold pause_in=1 for 3 ticks, then release.
- running drops after the first tick.
- x_offset stays 100 through the release tick.
- The next tick gives 100 + step.
REQ-031 Scenario (long vsync / reset-high vsync): vsync held high for 1600 cycles -> exactly 1 frame_tick. Reset released with vsync=1 -> 0 ticks until vsync goes low and rises again.
REQ-032 Scenario (mid-operation reset): assert reset for 1 cycle while in RUN at x_offset=250 with frame_count=77 -> next cycle x_offset=0, frame_count=0, running=0, state IDLE.
